// File: rtl/result_demux_1x2_pkg.sv
// Shared pipeline definitions for the result demux: buffer occupancy states
// and destination select constants.
package result_demux_1x2_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/result_demux_1x2_fifo2_buf.sv
// Two-entry in-order holding buffer of {sel, data} with a registered
// not-full flag so the producer never sees a path from the consumer readys.
module fifo2_buf
    import result_demux_1x2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output count_e           o_count,
    output logic             o_headSel,
    output logic [WIDTH-1:0] o_headData,
    output logic             o_inReady
);

    count_e           r_count;
    count_e           w_countNext;
    logic             r_inReady;
    logic             r_wrPtr;
    logic             r_rdPtr;
    logic [DEPTH-1:0] r_sel;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic             w_doPush;
    logic             w_doPop;

    // Guard both sides locally so a misbehaving caller cannot corrupt the pointers.
    assign w_doPush = i_push && r_inReady;
    assign w_doPop  = i_pop && (r_count != EMPTY);

    always_comb begin
        w_countNext = r_count;
        case (r_count)
            EMPTY: if (w_doPush) w_countNext = ONE;
            ONE: begin
                if (w_doPush && !w_doPop)      w_countNext = FULL;
                else if (w_doPop && !w_doPush) w_countNext = EMPTY;
            end
            FULL:    if (w_doPop) w_countNext = ONE;
            default: w_countNext = EMPTY;
        endcase
    end

    // Ready is computed from the next count, so it stays low through reset
    // and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= EMPTY;
            r_inReady <= 1'b0;
            r_wrPtr   <= 1'b0;
            r_rdPtr   <= 1'b0;
            r_sel     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_count   <= w_countNext;
            r_inReady <= (w_countNext != FULL);
            if (w_doPush) begin
                r_data[r_wrPtr] <= i_data;
                r_sel[r_wrPtr]  <= i_sel;
                r_wrPtr         <= ~r_wrPtr;
            end
            if (w_doPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
        end
    end

    assign o_count    = r_count;
    assign o_headSel  = r_sel[r_rdPtr];
    assign o_headData = r_data[r_rdPtr];
    assign o_inReady  = r_inReady;

endmodule

// File: rtl/result_demux_1x2.sv
// Routes buffered results to port A or B by their select bit, strictly in
// arrival order; a stalled head blocks everything behind it.
module result_demux_1x2
    import result_demux_1x2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data
);

    count_e           w_count;
    logic             w_headSel;
    logic [WIDTH-1:0] w_headData;
    logic             w_inReady;
    logic             w_nonEmpty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_outData;

    fifo2_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_sel      (in_sel),
        .i_data     (in_data),
        .i_pop      (w_pop),
        .o_count    (w_count),
        .o_headSel  (w_headSel),
        .o_headData (w_headData),
        .o_inReady  (w_inReady)
    );

    assign w_nonEmpty = (w_count != EMPTY);
    assign w_push     = in_valid && w_inReady;
    assign in_ready   = w_inReady;

    assign a_valid = w_nonEmpty && (w_headSel == SEL_A);
    assign b_valid = w_nonEmpty && (w_headSel == SEL_B);

    // Only the port the head targets can complete the pop.
    assign w_pop = (a_valid && a_ready) || (b_valid && b_ready);

    assign w_outData = w_nonEmpty ? w_headData : '0;
    assign a_data    = w_outData;
    assign b_data    = w_outData;

endmodule

// File: doc/result_demux_1x2.md
RESULT_DEMUX_1X2 -- requirements
Module: result_demux_1x2

Interface
REQ-001 Parameter WIDTH, default 32, data width of every data port.
REQ-002 Parameter DEPTH, fixed 2, entries in the internal holding buffer; other values are unsupported.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer presents a result.
REQ-006 in_ready  output  1  block accepts a result this cycle.
REQ-007 in_sel  input  1  destination select: 0 routes to port A, 1 routes to port B.
REQ-008 in_data  input  WIDTH  result payload.
REQ-009 a_valid  output  1  port A holds a result.
REQ-010 a_ready  input  1  port A consumer accepts.
REQ-011 a_data  output  WIDTH  port A payload.
REQ-012 b_valid  output  1  port B holds a result.
REQ-013 b_ready  input  1  port B consumer accepts.
REQ-014 b_data  output  WIDTH  port B payload.

Function
REQ-015 Transfers SHALL occur only on cycles where valid and ready are both 1 on the same port.
REQ-016 The block SHALL hold an in-order buffer of DEPTH {sel, data} entries, with count state EMPTY (0), ONE (1) or FULL (2).
REQ-017 in_ready SHALL be 1 exactly when count is not FULL; it SHALL be a registered function of count with no combinational path from a_ready or b_ready.
REQ-018 The head entry SHALL drive a_valid=1 when head sel=0, or b_valid=1 when head sel=1; a_valid and b_valid SHALL never both be 1.
REQ-019 a_data and b_data SHALL both equal the head data whenever the buffer is non-empty, and 0 when it is empty.
REQ-020 Minimum latency SHALL be 1 cycle: data accepted at edge N is valid on its port after edge N.
REQ-021 Ordering SHALL be strict FIFO; a stalled head SHALL block later entries even if they target the other port.
REQ-022 Transitions: EMPTY to ONE on push; ONE to FULL on push without pop; ONE to EMPTY on pop without push; ONE stays ONE on simultaneous push and pop; FULL to ONE on pop.
REQ-023 In ONE state, a simultaneous push and pop SHALL sustain one transfer per cycle.
REQ-024 In FULL state no push SHALL occur, because in_ready is 0.
REQ-025 Valid outputs and head data SHALL stay stable while the selected ready is 0.
REQ-026 Read and write pointers SHALL be 1 bit each and wrap from 1 to 0.

Reset
REQ-027 On rst_n=0, asynchronously: count=EMPTY, pointers=0, a_valid=0, b_valid=0, a_data=0, b_data=0, in_ready=0.
REQ-028 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered entries with no output handshake.

Structure
REQ-030 Count state encodings (EMPTY, ONE, FULL) and the destination constants SEL_A=0 and SEL_B=1 SHALL reside in the shared pipeline package.
REQ-031 Buffer storage and pointers SHALL be a sub-module fifo2_buf; result_demux_1x2 SHALL contain only the routing and valid decode.

Verification
REQ-032 Reset release, then push {sel=0, 0xDEADBEEF}: after 1 cycle a_valid=1, a_data=0xDEADBEEF, b_valid=0.
REQ-033 a_ready=0, push {0,0x1} then {1,0x2}: in_ready=0 after the second push and b_valid stays 0; then a_ready=1 -> 0x1 on A, then 0x2 on B.
REQ-034 Continuous pushes alternating sel, both readys held 1: one result delivered per cycle, in order, with no bubbles after the first.
REQ-035 Buffer FULL with in_valid=1 held and 0xCAFE presented: 0xCAFE is not accepted until in_ready returns to 1, and no entry is lost or duplicated.
REQ-036 rst_n pulsed low with 2 entries held: a_valid=0 and b_valid=0 immediately, and after release the next push appears alone.
